// File: rtl/fetch_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_redirect_unit: fetch-stage PC, single-outstanding I-mem requests,    |
// | IF/ID register with hazard stall and branch redirect. Macro:               |
// | MISALIGN_TRAP_EN enables the misaligned-target trap and HALT state.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        hazard_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        misalign_err_o
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DROP  = 3'd4
`ifdef MISALIGN_TRAP_EN
    , S_HALT = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        ifv_q, ifv_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifin_q, ifin_d;
  logic        w_halted;
  logic        w_misaligned;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

`ifdef MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  assign w_halted       = (state_q == S_HALT);
  assign w_misaligned   = (branch_target_i[1:0] != 2'b00);
  assign w_target       = branch_target_i;
  assign misalign_err_o = mis_q;
`else
  assign w_halted       = 1'b0;
  assign w_misaligned   = 1'b0;
  assign w_target       = branch_target_i & ~32'h0000_0003;
  assign misalign_err_o = 1'b0;
`endif

  assign w_pc_inc      = pc_q + 32'd4;
  assign imem_req_o    = (state_q == S_ISSUE);
  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = ifv_q;
  assign if_id_pc_o    = ifpc_q;
  assign if_id_instr_o = ifin_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    ifv_d   = ifv_q;
    ifpc_d  = ifpc_q;
    ifin_d  = ifin_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (w_halted) begin
      state_d = state_q;
    end else if (branch_taken_i) begin
      ifv_d  = 1'b0;
      ifin_d = NOP_INSTR;
      pc_d   = w_target;
      // A request already in flight must be drained before refetching.
      case (state_q)
        S_ISSUE: state_d = S_DROP;
        S_WAIT:  state_d = imem_valid_i ? S_ISSUE : S_DROP;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_ISSUE;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (w_misaligned) begin
        pc_d    = pc_q;
        mis_d   = 1'b1;
        state_d = S_HALT;
      end
`endif
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_valid_i) begin
            if (hazard_i) begin
              buf_d   = imem_rdata_i;
              state_d = S_HOLD;
            end else begin
              ifv_d   = 1'b1;
              ifpc_d  = pc_q;
              ifin_d  = imem_rdata_i;
              pc_d    = w_pc_inc;
              state_d = S_ISSUE;
            end
          end
        end
        S_HOLD: begin
          if (!hazard_i) begin
            ifv_d   = 1'b1;
            ifpc_d  = pc_q;
            ifin_d  = buf_q;
            pc_d    = w_pc_inc;
            state_d = S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_valid_i) state_d = S_ISSUE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      ifv_q   <= 1'b0;
      ifpc_q  <= 32'd0;
      ifin_q  <= NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      ifv_q   <= ifv_d;
      ifpc_q  <= ifpc_d;
      ifin_q  <= ifin_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  logic w_unused;
  assign w_unused = w_misaligned;

endmodule
`default_nettype wire
